// File: rtl/mcu_reg_bank_pkg.sv
// ----------------------------------------------------------------------------
// mcu_reg_bank_pkg
// Shared definitions for the MCU-mapped register bank:
//   - default geometry (register count, address and data widths)
//   - register address map of the capture/trigger core
//   - default read-only mask (key and SRAM readback registers)
//   - strobe edge selector used by the strobe synchroniser
// ----------------------------------------------------------------------------
package mcu_reg_bank_pkg;

    localparam int NUM_REGS_DEF    = 24;
    localparam int ADDR_W_DEF      = 5;
    localparam int DATA_W_DEF      = 8;
    localparam int COMMIT_ADDR_DEF = 2**ADDR_W_DEF - 1;

    // Which strobe transition produces an event.
    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_t;

    // Register address map. Multi-byte values (decimation, window count)
    // are split over consecutive addresses and only become visible to the
    // core together, on commit.
    localparam logic [ADDR_W_DEF-1:0] ADDR_DECIM_L  = 5'd0;
    localparam logic [ADDR_W_DEF-1:0] ADDR_DECIM_H0 = 5'd1;
    localparam logic [ADDR_W_DEF-1:0] ADDR_DECIM_H1 = 5'd2;
    localparam logic [ADDR_W_DEF-1:0] ADDR_TRIG_UP  = 5'd3;
    localparam logic [ADDR_W_DEF-1:0] ADDR_TRIG_DN  = 5'd4;
    localparam logic [ADDR_W_DEF-1:0] ADDR_WIN_L    = 5'd5;
    localparam logic [ADDR_W_DEF-1:0] ADDR_WIN_H0   = 5'd6;
    localparam logic [ADDR_W_DEF-1:0] ADDR_WIN_H1   = 5'd7;
    localparam logic [ADDR_W_DEF-1:0] ADDR_CNF_A    = 5'd8;
    localparam logic [ADDR_W_DEF-1:0] ADDR_CNF_B    = 5'd9;
    localparam logic [ADDR_W_DEF-1:0] ADDR_DELAY    = 5'd10;
    localparam logic [ADDR_W_DEF-1:0] ADDR_EXTPIN0  = 5'd11;
    localparam logic [ADDR_W_DEF-1:0] ADDR_EXTPIN1  = 5'd12;
    localparam logic [ADDR_W_DEF-1:0] ADDR_WRCTRL   = 5'd13;
    localparam logic [ADDR_W_DEF-1:0] ADDR_LA_COND  = 5'd14;
    localparam logic [ADDR_W_DEF-1:0] ADDR_LA_DIFF  = 5'd15;
    localparam logic [ADDR_W_DEF-1:0] ADDR_KEYS     = 5'd16;
    localparam logic [ADDR_W_DEF-1:0] ADDR_SRAM     = 5'd17;
    // Addresses 18..23 are implemented spares; 24..30 are unmapped.
    localparam logic [ADDR_W_DEF-1:0] ADDR_COMMIT   = 5'(COMMIT_ADDR_DEF);

    // One-hot bit for register idx within a NUM_REGS_DEF-wide mask.
    function automatic logic [NUM_REGS_DEF-1:0] reg_bit(input logic [ADDR_W_DEF-1:0] idx);
        return NUM_REGS_DEF'(1) << idx;
    endfunction

    // Keys and SRAM readback are sourced from the core, not the MCU.
    localparam logic [NUM_REGS_DEF-1:0] DEFAULT_RO_MASK =
        reg_bit(ADDR_KEYS) | reg_bit(ADDR_SRAM);

endpackage : mcu_reg_bank_pkg

// File: rtl/mcu_reg_bank_strobe_sync.sv
// ----------------------------------------------------------------------------
// strobe_sync
// Resynchronises an asynchronous MCU strobe into the clk domain and emits a
// registered one-cycle event on the selected edge.
// Latency from the strobe edge to evt is SYNC_STAGES+1 clk.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   strobe in  asynchronous strobe from the MCU
//   evt    out one-clk event on the selected strobe edge
// ----------------------------------------------------------------------------
module strobe_sync
    import mcu_reg_bank_pkg::*;
#(
    parameter int    SYNC_STAGES = 2,
    parameter edge_t EDGE        = EDGE_RISE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_seen;

    // Edge detect on the last synchroniser stage against its delayed copy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        edge_seen = 1'b0;
        if (EDGE == EDGE_RISE) begin
            edge_seen = sync_q[SYNC_STAGES-1] & ~prev_q;
        end else begin
            edge_seen = ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            evt    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
            prev_q <= sync_q[SYNC_STAGES-1];
            evt    <= edge_seen;
        end
    end

endmodule : strobe_sync

// File: rtl/mcu_reg_bank.sv
// ----------------------------------------------------------------------------
// mcu_reg_bank
// MCU-mapped register bank with shadow/commit. The MCU writes an address
// phase then data phases over an asynchronous strobe bus. Data lands in
// shadow registers; a data write to COMMIT_ADDR either copies every shadow to
// the active set in one cycle (DATA_IN[0]=1) or discards pending shadows by
// reloading them from the active set (DATA_IN[0]=0).
// Ports:
//   CLK           in  system clock
//   nRESET        in  asynchronous active-low reset
//   MCU_WR        in  async write strobe, acts on its rising edge
//   MCU_RD        in  async read strobe, auto-increments on its falling edge
//   Addr_or_Data  in  1: address phase, 0: data phase
//   DATA_IN       in  MCU write data
//   EXT_RD        in  read-only sources, slice i feeds register i
//   REG_DATA_OUT  out readback of the currently addressed register
//   REGS_ACTIVE   out committed register values, slice i = register i
//   WR_PULSE      out one-clk pulse when shadow i is written
//   COMMIT_PULSE  out one-clk pulse in the cycle REGS_ACTIVE updates
// ----------------------------------------------------------------------------
module mcu_reg_bank
    import mcu_reg_bank_pkg::*;
#(
    parameter int                  NUM_REGS    = NUM_REGS_DEF,
    parameter int                  ADDR_W      = ADDR_W_DEF,
    parameter int                  DATA_W      = DATA_W_DEF,
    parameter int                  SYNC_STAGES = 2,
    parameter bit                  AUTO_INC    = 1'b1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter int                  COMMIT_ADDR = 2**ADDR_W - 1
) (
    input  logic                       CLK,
    input  logic                       nRESET,
    input  logic                       MCU_WR,
    input  logic                       MCU_RD,
    input  logic                       Addr_or_Data,
    input  logic [DATA_W-1:0]          DATA_IN,
    input  logic [NUM_REGS*DATA_W-1:0] EXT_RD,
    output logic [DATA_W-1:0]          REG_DATA_OUT,
    output logic [NUM_REGS*DATA_W-1:0] REGS_ACTIVE,
    output logic [NUM_REGS-1:0]        WR_PULSE,
    output logic                       COMMIT_PULSE
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] COMMIT_A    = ADDR_W'(COMMIT_ADDR);

    logic                 wr_evt;
    logic                 rd_evt;
    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W-1:0]    addr_next_inc;
    logic                 addr_in_bank;
    logic [DATA_W-1:0]    shadow_q [NUM_REGS];
    logic [DATA_W-1:0]    active_q [NUM_REGS];

    // ------------------------------------------------------------------
    // Strobe resynchronisation
    // ------------------------------------------------------------------
    strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE        (EDGE_RISE)
    ) u_wr_sync (
        .clk    (CLK),
        .rst_n  (nRESET),
        .strobe (MCU_WR),
        .evt    (wr_evt)
    );

    strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE        (EDGE_FALL)
    ) u_rd_sync (
        .clk    (CLK),
        .rst_n  (nRESET),
        .strobe (MCU_RD),
        .evt    (rd_evt)
    );

    // ------------------------------------------------------------------
    // Address helpers: the pointer only walks the implemented range and
    // wraps from the last register back to 0; the commit address and
    // unmapped addresses stay put.
    // ------------------------------------------------------------------
    always_comb begin
        addr_in_bank  = (addr_q <= LAST_ADDR);
        addr_next_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Address pointer, shadow and active registers, pulses
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            addr_q       <= '0;
            WR_PULSE     <= '0;
            COMMIT_PULSE <= 1'b0;
            // NOTE: these arrays are plain flops, not RAM, so resetting every entry is intended.
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            WR_PULSE     <= '0;
            COMMIT_PULSE <= 1'b0;

            if (wr_evt) begin
                // A write wins over a coincident read event; the read's
                // increment is dropped so the pointer moves at most once.
                if (Addr_or_Data) begin
                    addr_q <= DATA_IN[ADDR_W-1:0];
                end else if (addr_in_bank) begin
                    if (!RO_MASK[addr_q]) begin
                        shadow_q[addr_q] <= DATA_IN;
                        WR_PULSE[addr_q] <= 1'b1;
                    end
                    if (AUTO_INC) begin
                        addr_q <= addr_next_inc;
                    end
                end else if (addr_q == COMMIT_A) begin
                    if (DATA_IN[0]) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            active_q[i] <= shadow_q[i];
                        end
                        COMMIT_PULSE <= 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            shadow_q[i] <= active_q[i];
                        end
                    end
                end
            end else if (rd_evt && AUTO_INC && addr_in_bank) begin
                addr_q <= addr_next_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Readback: read-only registers show the external source, writable
    // registers show the pending shadow so the MCU can verify its writes
    // before committing. Unmapped and commit addresses read as 0.
    // ------------------------------------------------------------------
    always_comb begin
        REG_DATA_OUT = '0;
        if (addr_in_bank) begin
            if (RO_MASK[addr_q]) begin
                REG_DATA_OUT = EXT_RD[int'(addr_q)*DATA_W +: DATA_W];
            end else begin
                REG_DATA_OUT = shadow_q[addr_q];
            end
        end
    end

    // Flattened committed values for the capture/trigger core.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_active_flat
        assign REGS_ACTIVE[g*DATA_W +: DATA_W] = active_q[g];
    end

endmodule : mcu_reg_bank

// File: tb/tb_mcu_reg_bank.sv
// ----------------------------------------------------------------------------
// tb_mcu_reg_bank
// Self-checking bench for mcu_reg_bank: directed scenarios followed by a
// random sequence of MCU bus operations, compared against a bus-level model
// of the register bank.
// ----------------------------------------------------------------------------
module tb_mcu_reg_bank;
    import mcu_reg_bank_pkg::*;

    localparam int NR   = 24;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int SS   = 2;
    localparam int CADR = 31;
    localparam logic [NR-1:0] ROM = DEFAULT_RO_MASK;
    localparam int WIN  = 12;

    logic               clk;
    logic               nreset;
    logic               mcu_wr;
    logic               mcu_rd;
    logic               aod;
    logic [DW-1:0]      data_in;
    logic [NR*DW-1:0]   ext_rd;
    logic [DW-1:0]      reg_data_out;
    logic [NR*DW-1:0]   regs_active;
    logic [NR-1:0]      wr_pulse;
    logic               commit_pulse;

    mcu_reg_bank #(
        .NUM_REGS    (NR),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SYNC_STAGES (SS),
        .AUTO_INC    (1'b1),
        .RO_MASK     (ROM),
        .COMMIT_ADDR (CADR)
    ) dut (
        .CLK          (clk),
        .nRESET       (nreset),
        .MCU_WR       (mcu_wr),
        .MCU_RD       (mcu_rd),
        .Addr_or_Data (aod),
        .DATA_IN      (data_in),
        .EXT_RD       (ext_rd),
        .REG_DATA_OUT (reg_data_out),
        .REGS_ACTIVE  (regs_active),
        .WR_PULSE     (wr_pulse),
        .COMMIT_PULSE (commit_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: bus-level view of the bank
    // ------------------------------------------------------------------
    int      m_addr;
    int      m_shadow [NR];
    int      m_active [NR];

    function automatic bit is_ro(input int i);
        return ((ROM >> i) & 1) != 0;
    endfunction

    task automatic model_reset();
        m_addr = 0;
        for (int i = 0; i < NR; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
    endtask

    function automatic int model_rd();
        if (m_addr < NR) begin
            if (is_ro(m_addr)) return int'(ext_rd[m_addr*DW +: DW]);
            return m_shadow[m_addr];
        end
        return 0;
    endfunction

    function automatic logic [NR*DW-1:0] model_active();
        logic [NR*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = DW'(m_active[i]);
        return r;
    endfunction

    // Applies one MCU write; returns the pulses it should produce.
    task automatic model_write(input bit a_phase, input int d,
                               output logic [NR-1:0] exp_mask, output bit exp_commit);
        exp_mask   = '0;
        exp_commit = 1'b0;
        if (a_phase) begin
            m_addr = d % 32;
        end else if (m_addr < NR) begin
            if (!is_ro(m_addr)) begin
                m_shadow[m_addr] = d;
                exp_mask = NR'(1) << m_addr;
            end
            m_addr = (m_addr + 1) % NR;
        end else if (m_addr == CADR) begin
            if ((d % 2) == 1) begin
                for (int i = 0; i < NR; i++) m_active[i] = m_shadow[i];
                exp_commit = 1'b1;
            end else begin
                for (int i = 0; i < NR; i++) m_shadow[i] = m_active[i];
            end
        end
    endtask

    task automatic model_read();
        if (m_addr < NR) m_addr = (m_addr + 1) % NR;
    endtask

    // ------------------------------------------------------------------
    // Bus tasks
    // ------------------------------------------------------------------
    task automatic check_state(input string tag);
        check({tag, "_rdback"}, reg_data_out, model_rd());
        check({tag, "_active"}, regs_active, model_active());
    endtask

    // with_rd: release MCU_RD in the same instant MCU_WR rises, so both
    // events land in one clock cycle.
    task automatic bus_write(input bit a_phase, input logic [DW-1:0] d, input bit with_rd);
        logic [NR-1:0]    exp_mask;
        bit               exp_commit;
        logic [NR-1:0]    pulse_or;
        int               pulse_cycles, pulse_first;
        int               commit_cycles, commit_first;
        int               glitches;
        logic [NR*DW-1:0] prev_act;

        @(negedge clk);
        if (with_rd) begin
            mcu_rd = 1'b1;
            repeat (SS + 3) @(negedge clk);
        end
        model_write(a_phase, int'(d), exp_mask, exp_commit);
        data_in = d;
        aod     = a_phase;
        mcu_wr  = 1'b1;
        if (with_rd) mcu_rd = 1'b0;

        pulse_or = '0;
        pulse_cycles = 0; pulse_first = 0;
        commit_cycles = 0; commit_first = 0;
        glitches = 0;
        prev_act = regs_active;
        for (int k = 1; k <= WIN; k++) begin
            @(posedge clk);
            #1;
            if (wr_pulse != '0) begin
                pulse_or |= wr_pulse;
                pulse_cycles++;
                if (pulse_first == 0) pulse_first = k;
            end
            if (commit_pulse) begin
                commit_cycles++;
                if (commit_first == 0) commit_first = k;
            end
            if (regs_active != prev_act && !commit_pulse) glitches++;
            prev_act = regs_active;
            if (k == WIN - 4) begin
                @(negedge clk);
                mcu_wr = 1'b0;
            end
        end

        check("wr_pulse_mask", pulse_or, exp_mask);
        check("wr_pulse_width", pulse_cycles, (exp_mask != '0) ? 1 : 0);
        if (exp_mask != '0) check("wr_pulse_latency", pulse_first, SS + 2);
        check("commit_width", commit_cycles, exp_commit ? 1 : 0);
        if (exp_commit) check("commit_latency", commit_first, SS + 2);
        check("active_only_on_commit", glitches, 0);
        check_state("wr");
    endtask

    task automatic bus_read();
        check("rd_before", reg_data_out, model_rd());
        @(negedge clk);
        mcu_rd = 1'b1;
        repeat (SS + 3) @(negedge clk);
        mcu_rd = 1'b0;
        repeat (SS + 4) @(negedge clk);
        model_read();
        check("rd_after", reg_data_out, model_rd());
    endtask

    task automatic set_ext(input int idx, input logic [DW-1:0] v);
        @(negedge clk);
        ext_rd[idx*DW +: DW] = v;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        nreset  = 1'b0;
        mcu_wr  = 1'b0;
        mcu_rd  = 1'b0;
        aod     = 1'b0;
        data_in = '0;
        ext_rd  = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("reset_wr_pulse", wr_pulse, '0);
        check("reset_commit", commit_pulse, 1'b0);
        check_state("reset");
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Multi-byte staging: shadows change, active stays put.
        bus_write(1'b1, 8'h00, 1'b0);
        bus_write(1'b0, 8'h11, 1'b0);
        bus_write(1'b0, 8'h22, 1'b0);
        bus_write(1'b0, 8'h33, 1'b0);
        check("staged_active_zero", regs_active, '0);

        // Commit.
        bus_write(1'b1, 8'(CADR), 1'b0);
        bus_write(1'b0, 8'h01, 1'b0);
        check("commit_low3", regs_active[3*DW-1:0], 24'h33_22_11);

        // Discard of a pending write.
        bus_write(1'b1, 8'h03, 1'b0);
        bus_write(1'b0, 8'hAA, 1'b0);
        bus_write(1'b1, 8'(CADR), 1'b0);
        bus_write(1'b0, 8'h00, 1'b0);
        bus_write(1'b1, 8'h03, 1'b0);
        check("discard_rdback", reg_data_out, 8'h00);

        // Read-only register ignores writes and shows its source.
        set_ext(int'(ADDR_KEYS), 8'h15);
        bus_write(1'b1, 8'(ADDR_KEYS), 1'b0);
        bus_write(1'b0, 8'hFF, 1'b0);
        bus_write(1'b1, 8'(ADDR_KEYS), 1'b0);
        check("ro_rdback", reg_data_out, 8'h15);

        // Read at the last register wraps the pointer to 0.
        bus_write(1'b1, 8'(NR - 1), 1'b0);
        bus_read();
        check("wrap_rdback", reg_data_out, 8'h11);

        // Coincident read and write events: single increment.
        bus_write(1'b1, 8'h05, 1'b0);
        bus_write(1'b0, 8'h5A, 1'b1);
        bus_write(1'b0, 8'h66, 1'b1);
        bus_write(1'b1, 8'h06, 1'b0);
        check("simul_rdback", reg_data_out, 8'h66);

        // Reset in the middle of a write strobe.
        @(negedge clk);
        aod     = 1'b0;
        data_in = 8'h77;
        mcu_wr  = 1'b1;
        repeat (2) @(negedge clk);
        nreset = 1'b0;
        #1;
        model_reset();
        check("midreset_wr_pulse", wr_pulse, '0);
        check("midreset_commit", commit_pulse, 1'b0);
        check_state("midreset");
        mcu_wr = 1'b0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (SS + 4) @(negedge clk);
        check_state("after_reset");

        // Random bus traffic.
        for (int n = 0; n < 150; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1: begin
                    if ($urandom_range(0, 3) == 0) bus_write(1'b1, 8'(CADR), 1'b0);
                    else bus_write(1'b1, 8'($urandom_range(0, 27)), 1'b0);
                end
                2, 3, 4, 5: bus_write(1'b0, 8'($urandom), 1'b0);
                6, 7:       bus_read();
                8:          bus_write(1'b0, 8'($urandom), 1'b1);
                default: begin
                    @(negedge clk);
                    for (int i = 0; i < NR; i++) ext_rd[i*DW +: DW] = 8'($urandom);
                    #1;
                    check("ext_rdback", reg_data_out, model_rd());
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mcu_reg_bank
